oh_nand2_pipe: RTL and testbench

OH_NAND2_PIPE -- requirements
Module: oh_nand2_pipe

---
 rtl/oh_nand2_pipe.sv | 62 ++++++
 tb/tb_oh_nand2_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/oh_nand2_pipe.sv
// Pipelined N-bit bitwise NAND with S register stages, a valid flag per stage
// and a mux-scan chain threaded through all data bits.
module oh_nand2_pipe #(
   parameter int N = 8,
   parameter int S = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         valid_in,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         se,
   input  logic         si,
   output logic [N-1:0] z,
   output logic         valid_out,
   output logic         so
);

   localparam int W = S * N;

   // Stage k occupies chain_p[k*N +: N]; bit 0 of the vector is the scan-in end.
   logic [W-1:0] chain_p;
   logic [W-1:0] chain_nxt;
   logic [S-1:0] vld_p;
   logic [S-1:0] vld_nxt;

   function automatic logic [N-1:0] nand2(input logic [N-1:0] x, input logic [N-1:0] y);
      return ~(x & y);
   endfunction

   always_comb begin
      chain_nxt = chain_p;
      vld_nxt   = vld_p;
      if (se) begin
         chain_nxt    = chain_p << 1;
         chain_nxt[0] = si;
         vld_nxt      = '0;
      end else if (en) begin
         chain_nxt        = chain_p << N;
         chain_nxt[N-1:0] = nand2(a, b);
         vld_nxt          = vld_p << 1;
         vld_nxt[0]       = valid_in;
      end
   end

   // stage registers: reset > scan shift > enabled advance > hold
   always_ff @(posedge clk) begin
      if (reset) begin
         chain_p <= '0;
         vld_p   <= '0;
      end else begin
         chain_p <= chain_nxt;
         vld_p   <= vld_nxt;
      end
   end

   assign z         = chain_p[W-1 -: N];
   assign valid_out = vld_p[S-1];
   assign so        = chain_p[W-1];

endmodule

// File: tb/tb_oh_nand2_pipe.sv
// Randomized and directed checking of oh_nand2_pipe against a word-level
// behavioural model of the pipeline and scan chain.
module tb_oh_nand2_pipe;
   localparam int N = 8;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         valid_in = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         se = 1'b0;
   logic         si = 1'b0;
   logic [N-1:0] z;
   logic         valid_out;
   logic         so;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   oh_nand2_pipe #(.N(N), .S(S)) dut (
      .clk(clk), .reset(reset), .en(en), .valid_in(valid_in),
      .a(a), .b(b), .se(se), .si(si),
      .z(z), .valid_out(valid_out), .so(so)
   );

   // Model: one word and one valid flag per stage; scan ripples bits word to word.
   logic [N-1:0] m_stg [S];
   logic         m_vld [S];
   bit           m_known = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < S; k++) begin
            m_stg[k] <= '0;
            m_vld[k] <= 1'b0;
         end
         m_known <= 1'b1;
      end else if (se) begin
         for (int k = 0; k < S; k++) begin
            m_stg[k] <= {m_stg[k][N-2:0], (k == 0) ? si : m_stg[k-1][N-1]};
            m_vld[k] <= 1'b0;
         end
      end else if (en) begin
         for (int k = 1; k < S; k++) begin
            m_stg[k] <= m_stg[k-1];
            m_vld[k] <= m_vld[k-1];
         end
         m_stg[0] <= ~(a & b);
         m_vld[0] <= valid_in;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_known) begin
         chk("model_z", z, m_stg[S-1]);
         chk("model_valid_out", valid_out, m_vld[S-1]);
         chk("model_so", so, m_stg[S-1][N-1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; se = 1'b0; en = 1'b0; valid_in = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] w1, w2;
      logic [15:0]  em;
      bit           seen;

      // reset state
      do_reset();
      chk("reset_z", z, 8'h00);
      chk("reset_valid", valid_out, 1'b0);
      chk("reset_so", so, 1'b0);

      // single transaction, latency two
      en = 1'b1; valid_in = 1'b1; a = 8'hF0; b = 8'hCC;
      tick();
      valid_in = 1'b0; a = 8'h00; b = 8'h00;
      chk("func_lat1_valid", valid_out, 1'b0);
      tick();
      chk("func_z", z, 8'h3F);
      chk("func_valid", valid_out, 1'b1);
      tick();
      chk("func_valid_once", valid_out, 1'b0);

      // stall for three cycles after the first edge
      do_reset();
      en = 1'b1; valid_in = 1'b1; a = 8'hF0; b = 8'hCC;
      tick();
      en = 1'b0; valid_in = 1'b0; a = 8'h12; b = 8'h34;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", valid_out, 1'b0);
         chk("stall_z", z, 8'h00);
      end
      en = 1'b1;
      tick();
      chk("stall_z_out", z, 8'h3F);
      chk("stall_valid_out", valid_out, 1'b1);

      // back-to-back pairs
      do_reset();
      en = 1'b1; valid_in = 1'b1;
      a = 8'hFF; b = 8'hFF; tick();
      a = 8'h00; b = 8'hFF; tick();
      chk("b2b_z0", z, 8'h00);
      chk("b2b_v0", valid_out, 1'b1);
      a = 8'hAA; b = 8'h55; tick();
      chk("b2b_z1", z, 8'hFF);
      chk("b2b_v1", valid_out, 1'b1);
      valid_in = 1'b0; tick();
      chk("b2b_z2", z, 8'hFF);
      chk("b2b_v2", valid_out, 1'b1);
      tick();
      chk("b2b_end", valid_out, 1'b0);

      // scan load over valid in-flight data
      do_reset();
      en = 1'b1; valid_in = 1'b1; a = 8'h0F; b = 8'hFF; tick();
      w1 = 8'h3C; w2 = 8'hA5;
      se = 1'b1;
      for (int i = 0; i < 16; i++) begin
         si = (i < 8) ? w1[i] : w2[i-8];
         tick();
         chk("scan_valid_clear", valid_out, 1'b0);
      end
      se = 1'b0; en = 1'b0;
      tick();
      chk("scan_z", z, 8'h3C);
      chk("scan_valid", valid_out, 1'b0);
      se = 1'b1; si = 1'b0;
      for (int i = 0; i < 16; i++) begin
         em[i] = so;
         tick();
      end
      chk("scan_unload", em, 16'hA53C);

      // resume functional mode with scanned contents in place
      for (int i = 0; i < 16; i++) begin
         si = (i < 8) ? w1[i] : w2[i-8];
         tick();
      end
      se = 1'b0; en = 1'b1; valid_in = 1'b0; a = 8'hFF; b = 8'hFF;
      tick();
      chk("resume_z", z, 8'hA5);
      chk("resume_valid", valid_out, 1'b0);

      // priority: reset over scan over enable
      reset = 1'b1; se = 1'b1; en = 1'b1; valid_in = 1'b1; si = 1'b1;
      tick();
      chk("prio_reset_z", z, 8'h00);
      chk("prio_reset_v", valid_out, 1'b0);
      chk("prio_reset_so", so, 1'b0);
      reset = 1'b0; a = 8'hF0; b = 8'hCC;
      for (int i = 0; i < 9; i++) tick();
      chk("prio_scan_z", z, 8'h01);
      chk("prio_scan_v", valid_out, 1'b0);

      // reset mid-flight
      do_reset();
      se = 1'b0; en = 1'b1; valid_in = 1'b1; a = 8'hF0; b = 8'hCC;
      tick();
      reset = 1'b1; valid_in = 1'b0; a = 8'hFF; b = 8'hFF;
      tick();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (valid_out) seen = 1'b1;
         chk("midreset_z", z, 8'h00);
      end
      chk("midreset_never_valid", seen, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(63) == 0);
         se       = ($urandom_range(7) == 0);
         en       = ($urandom_range(3) != 0);
         valid_in = $urandom_range(1);
         si       = $urandom_range(1);
         a        = N'($urandom);
         b        = N'($urandom);
         tick();
      end

      reset = 1'b0; se = 1'b0; en = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
